// File: rtl/image_ram_bridge.sv
// ---------------------------------------------------------------------------
// image_ram_bridge
//
// Responder end of the MCU<->FPGA image-transfer protocol. A load phase takes
// IMAGE_SIZE pixel bytes from the MCU receive stream and writes them to RAM
// addresses 0..IMAGE_SIZE-1. A read phase streams the same addresses back to
// the MCU, in ascending order.
//
// Optional feature: define BRIDGE_CHECKSUM_EN to enable the 16-bit running
// phase checksum. When the macro is undefined, checksum is tied to 0 and no
// adder is built.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   ld_start/rd_start one-cycle start pulses from the sequencer
//   ld_done/rd_done   one-cycle phase-complete pulses
//   busy              high whenever the FSM is not in IDLE
//   start_err         one-cycle pulse when a start is rejected or conflicts
//   rx_data/valid/ready   MCU -> bridge pixel stream
//   tx_data/valid/ready   bridge -> MCU pixel stream
//   ram_addr/wdata/we     single-port RAM request side
//   ram_rdata             RAM read data, one cycle after ram_addr
//   checksum              running phase checksum
//   state_dbg             current FSM state, for observation only
//
// Handshake rule, both streams: a byte moves on a rising edge where valid and
// ready are both high. Once raised, valid stays high and data stays stable
// until that edge. ready does not wait on valid.
// ---------------------------------------------------------------------------
module image_ram_bridge #(
  parameter int IMAGEX           = 0,
  parameter int IMAGEY           = 0,
  // If the image dimensions are left at 0, the design falls back to a legal
  // single-pixel size and a 1-bit address. This keeps every vector width
  // positive.
  parameter int IMAGE_SIZE       = (IMAGEX * IMAGEY > 0) ? IMAGEX * IMAGEY : 1,
  parameter int IMAGE_ADDR_WIDTH = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1,
  parameter int RGB_SIZE         = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_start,
  input  logic                        rd_start,
  output logic                        ld_done,
  output logic                        rd_done,
  output logic                        busy,
  output logic                        start_err,
  input  logic [RGB_SIZE-1:0]         rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic [RGB_SIZE-1:0]         tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [IMAGE_ADDR_WIDTH-1:0] ram_addr,
  output logic [RGB_SIZE-1:0]         ram_wdata,
  output logic                        ram_we,
  input  logic [RGB_SIZE-1:0]         ram_rdata,
  output logic [15:0]                 checksum,
  output logic [2:0]                  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_LOAD_DONE = 3'd2,
    S_RD_ISSUE  = 3'd3,
    S_RD_WAIT   = 3'd4,
    S_RD_HOLD   = 3'd5,
    S_RD_DONE   = 3'd6
  } state_t;

  // The last pixel index ends a phase. This holds even when the address bus
  // is wider than the image needs, so cnt never wraps.
  localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);

  state_t                      state;
  logic [IMAGE_ADDR_WIDTH-1:0] cnt;

  assign busy      = (state != S_IDLE);
  assign rx_ready  = (state == S_LOAD);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      ld_done   <= 1'b0;
      rd_done   <= 1'b0;
      start_err <= 1'b0;
    end else begin
      ram_we    <= 1'b0;
      ld_done   <= 1'b0;
      rd_done   <= 1'b0;
      // In IDLE, only a simultaneous request is an error; load wins it.
      // In any other state, every start request is refused.
      start_err <= (state == S_IDLE) ? (ld_start && rd_start) : (ld_start || rd_start);

      case (state)
        S_IDLE: begin
          if (ld_start) begin
            state <= S_LOAD;
            cnt   <= '0;
          end else if (rd_start) begin
            // Address 0 goes out during RD_ISSUE, so its data is back in RD_WAIT.
            state    <= S_RD_ISSUE;
            cnt      <= '0;
            ram_addr <= '0;
          end
        end

        S_LOAD: begin
          if (rx_valid) begin
            ram_we    <= 1'b1;
            ram_addr  <= cnt;
            ram_wdata <= rx_data;
            if (cnt == LAST) begin
              state   <= S_LOAD_DONE;
              ld_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_LOAD_DONE: state <= S_IDLE;

        S_RD_ISSUE: begin
          ram_addr <= cnt;
          state    <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          tx_data  <= ram_rdata;
          tx_valid <= 1'b1;
          state    <= S_RD_HOLD;
        end

        S_RD_HOLD: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (cnt == LAST) begin
              state   <= S_RD_DONE;
              rd_done <= 1'b1;
            end else begin
              cnt      <= cnt + 1'b1;
              ram_addr <= cnt + 1'b1;
              state    <= S_RD_ISSUE;
            end
          end
        end

        S_RD_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BRIDGE_CHECKSUM_EN
  logic [15:0] csum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum <= 16'h0;
    end else if (state == S_IDLE && (ld_start || rd_start)) begin
      csum <= 16'h0;
    end else if (state == S_LOAD && rx_valid) begin
      csum <= csum + 16'(rx_data);
    end else if (state == S_RD_HOLD && tx_valid && tx_ready) begin
      csum <= csum + 16'(tx_data);
    end
  end

  assign checksum = csum;
`else
  assign checksum = 16'h0;
`endif

endmodule

// File: tb/tb_image_ram_bridge.sv
module tb_image_ram_bridge;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT0: 2x2 image, 3-bit address ----------------
  logic       ld_start = 0, rd_start = 0, ld_done, rd_done, busy, start_err;
  logic [7:0] rx_data = 0, tx_data, ram_wdata, ram_rdata;
  logic       rx_valid = 0, rx_ready, tx_valid, tx_ready = 0, ram_we;
  logic [2:0] ram_addr, state_dbg;
  logic [15:0] checksum;

  image_ram_bridge #(.IMAGEX(2), .IMAGEY(2), .IMAGE_ADDR_WIDTH(3), .RGB_SIZE(8)) u_dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .rd_start(rd_start),
    .ld_done(ld_done), .rd_done(rd_done), .busy(busy), .start_err(start_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .checksum(checksum), .state_dbg(state_dbg)
  );

  logic [7:0] ram0 [0:7];
  always @(posedge clk) begin
    if (ram_we) ram0[ram_addr] <= ram_wdata;
    ram_rdata <= ram0[ram_addr];
  end

  // ---------------- DUT1: single-pixel image ----------------
  logic       ld_start_1 = 0, ld_done_1, rd_done_1, busy_1, start_err_1;
  logic [7:0] rx_data_1 = 0, tx_data_1, ram_wdata_1, ram_rdata_1;
  logic       rx_valid_1 = 0, rx_ready_1, tx_valid_1, ram_we_1;
  logic       rd_start_1 = 0, tx_ready_1 = 0;
  logic [0:0] ram_addr_1;
  logic [2:0] state_dbg_1;
  logic [15:0] checksum_1;

  image_ram_bridge #(.IMAGEX(1), .IMAGEY(1), .IMAGE_ADDR_WIDTH(1), .RGB_SIZE(8)) u_dut1 (
    .clk(clk), .rst(rst), .ld_start(ld_start_1), .rd_start(rd_start_1),
    .ld_done(ld_done_1), .rd_done(rd_done_1), .busy(busy_1), .start_err(start_err_1),
    .rx_data(rx_data_1), .rx_valid(rx_valid_1), .rx_ready(rx_ready_1),
    .tx_data(tx_data_1), .tx_valid(tx_valid_1), .tx_ready(tx_ready_1),
    .ram_addr(ram_addr_1), .ram_wdata(ram_wdata_1), .ram_we(ram_we_1),
    .ram_rdata(ram_rdata_1), .checksum(checksum_1), .state_dbg(state_dbg_1)
  );

  logic [7:0] ram1 [0:1];
  always @(posedge clk) begin
    if (ram_we_1) ram1[ram_addr_1] <= ram_wdata_1;
    ram_rdata_1 <= ram1[ram_addr_1];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_wr_q[$];   // {addr, data} for expected DUT0 RAM writes
  logic [31:0] exp_wr1_q[$];  // same, DUT1
  logic [31:0] exp_q[$];      // expected tx bytes
  logic [7:0]  img [0:3];     // bench model of the image held in RAM
  int we_cyc[$];
  int tx_cyc[$];
  int ld_done_cnt = 0, rd_done_cnt = 0, err_cnt = 0, rd_done_cyc = 0;
  int ld_done1_cnt = 0, we1_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ck_exp(input logic [15:0] v);
`ifdef BRIDGE_CHECKSUM_EN
    return {16'h0, v};
`else
    return (v == 16'hFFFF) ? 32'h0 : 32'h0;
`endif
  endfunction

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      if (ram_we) begin
        we_cyc.push_back(cyc);
        if (exp_wr_q.size() == 0) chk("wr_unexpected_q_size", exp_wr_q.size(), 1);
        else chk("ram_write", {21'h0, ram_addr, ram_wdata}, exp_wr_q.pop_front());
      end
      if (ld_done) begin
        ld_done_cnt++;
        chk("ld_done_with_last_we", {ram_we, ram_addr}, {1'b1, 3'd3});
      end
      if (rd_done) begin
        rd_done_cnt++;
        rd_done_cyc = cyc;
      end
      if (start_err) err_cnt++;
      if (ram_we_1) begin
        we1_cnt++;
        if (exp_wr1_q.size() == 0) chk("wr1_unexpected_q_size", exp_wr1_q.size(), 1);
        else chk("ram_write_1", {23'h0, ram_addr_1, ram_wdata_1}, exp_wr1_q.pop_front());
      end
      if (ld_done_1) begin
        ld_done1_cnt++;
        chk("ld_done_1_with_we", ram_we_1, 1);
      end
    end
  end

  // ---------------- drivers ----------------
  // Load four bytes into DUT0. "both" also pulses rd_start with ld_start.
  // When inj >= 0, a rd_start pulse goes out on that load cycle.
  task automatic run_load(input logic [7:0] b [4], input bit both, input int inj);
    int i;
    int t;
    bit hs;
    ld_done_cnt = 0; err_cnt = 0; rd_done_cnt = 0; we_cyc.delete();
    @(negedge clk); ld_start = 1; rd_start = both;
    @(negedge clk); ld_start = 0; rd_start = 0;
    chk("busy_in_load", busy, 1);
    i = 0; t = 0;
    while (i < 4 && t < 50) begin
      rx_data = b[i]; rx_valid = 1;
      rd_start = (t == inj);
      hs = rx_ready;
      if (hs) begin
        exp_wr_q.push_back({21'h0, 3'(i), b[i]});
        img[i] = b[i];
      end
      @(negedge clk);
      rd_start = 0;
      if (hs) i++;
      t++;
    end
    rx_valid = 0;
    chk("load_bytes_taken", i, 4);
    repeat (3) @(negedge clk);
    chk("ld_done_count", ld_done_cnt, 1);
    chk("we_count", we_cyc.size(), 4);
    if (we_cyc.size() == 4) chk("we_consecutive", we_cyc[3] - we_cyc[0], 3);
    chk("wr_q_drained", exp_wr_q.size(), 0);
    chk("busy_after_load", busy, 0);
  endtask

  // Read four bytes back. stall_idx < 0 keeps tx_ready high throughout.
  // Otherwise the byte with that index is held off for 5 cycles.
  task automatic run_read(input int stall_idx);
    int n;
    int t;
    int stall;
    rd_done_cnt = 0; tx_cyc.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back({24'h0, img[k]});
    tx_ready = (stall_idx < 0);
    @(negedge clk); rd_start = 1;
    @(negedge clk); rd_start = 0;
    n = 0; t = 0; stall = 0;
    while (n < 4 && t < 200) begin
      if (tx_valid) begin
        if (n == stall_idx && stall < 5) begin
          tx_ready = 0;
          chk("stall_valid", tx_valid, 1);
          chk("stall_data", tx_data, exp_q[0]);
          stall++;
        end else begin
          tx_ready = 1;
          chk("tx_byte", tx_data, exp_q.pop_front());
          tx_cyc.push_back(cyc);
          n++;
        end
      end else begin
        tx_ready = (stall_idx < 0);
      end
      @(negedge clk);
      t++;
    end
    chk("read_bytes_seen", n, 4);
    tx_ready = 0;
    repeat (3) @(negedge clk);
    chk("rd_done_count", rd_done_cnt, 1);
    if (tx_cyc.size() == 4) begin
      chk("rd_done_timing", rd_done_cyc, tx_cyc[3] + 1);
      if (stall_idx < 0)
        for (int k = 1; k < 4; k++) chk("tx_spacing", tx_cyc[k] - tx_cyc[k-1], 3);
    end
    chk("tx_valid_idle", tx_valid, 0);
    chk("exp_q_drained", exp_q.size(), 0);
    if (stall_idx >= 0) chk("stall_cycles", stall, 5);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] b [4];
    int k;

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_start_err", start_err, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_state", state_dbg, 0);
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);

    // First load, then a read with tx_ready held high
    b = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_load(b, 0, -1);
    chk("load_start_err", err_cnt, 0);
    chk("load_checksum", checksum, ck_exp(16'h00A0));
    run_read(-1);
    chk("read_checksum", checksum, ck_exp(16'h00A0));

    // Same read again, holding byte 2 off for 5 cycles
    run_read(2);
    chk("stall_read_checksum", checksum, ck_exp(16'h00A0));

    // Both starts together in IDLE, plus a rd_start partway through the load
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(b, 1, 1);
    chk("conflict_start_err", err_cnt, 2);
    chk("conflict_no_read", rd_done_cnt, 0);
    chk("conflict_checksum", checksum, ck_exp(16'h00AA));

    // Reset after two of four load bytes
    ld_done_cnt = 0;
    @(negedge clk); ld_start = 1;
    @(negedge clk); ld_start = 0;
    for (k = 0; k < 2; k++) begin
      rx_data = 8'h51 + 8'(k); rx_valid = 1;
      chk("abort_rx_ready", rx_ready, 1);
      exp_wr_q.push_back({21'h0, 3'(k), 8'h51 + 8'(k)});
      img[k] = 8'h51 + 8'(k);
      @(negedge clk);
    end
    rx_valid = 0;
    @(negedge clk);
    chk("abort_busy_before", busy, 1);
    #1 rst = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rx_ready_low", rx_ready, 0);
    chk("abort_ram_we", ram_we, 0);
    chk("abort_ram_addr", ram_addr, 0);
    chk("abort_ld_done", ld_done, 0);
    chk("abort_checksum", checksum, 0);
    chk("abort_state", state_dbg, 0);
    @(negedge clk); rst = 1;
    @(negedge clk);
    chk("abort_no_ld_done", ld_done_cnt, 0);
    chk("abort_wr_q_drained", exp_wr_q.size(), 0);
    run_read(-1);

    // Single-pixel image, with rx_valid low for 3 cycles before the byte arrives
    @(negedge clk); ld_start_1 = 1;
    @(negedge clk); ld_start_1 = 0;
    rx_valid_1 = 0;
    repeat (3) @(negedge clk);
    chk("one_rx_ready", rx_ready_1, 1);
    chk("one_no_early_we", we1_cnt, 0);
    rx_data_1 = 8'hFF; rx_valid_1 = 1;
    exp_wr1_q.push_back({23'h0, 1'b0, 8'hFF});
    @(negedge clk); rx_valid_1 = 0;
    repeat (3) @(negedge clk);
    chk("one_we_count", we1_cnt, 1);
    chk("one_ld_done_count", ld_done1_cnt, 1);
    chk("one_wr_q_drained", exp_wr1_q.size(), 0);
    chk("one_busy_after", busy_1, 0);
    chk("one_checksum", checksum_1, ck_exp(16'h00FF));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
